request_encoder: RTL and testbench

REQUEST_ENCODER -- requirements
Module: request_encoder

---
 rtl/request_encoder_pkg.sv | 26 ++
 rtl/request_encoder_prio_enc.sv | 31 +++
 rtl/request_encoder.sv | 89 ++++++++
 tb/tb_request_encoder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/request_encoder_pkg.sv
// Shared definitions for the request encoder: default size, width helper
// and the output-state encoding (the state is carried by valid).
package request_encoder_pkg;

    localparam int N_DEFAULT = 4;

    // Output register state; FULL means a serviced index is presented.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    // Smallest w such that 2**w >= n (ceil(log2(n))), bounded loop so it
    // elaborates as a constant function.
    function automatic int clog2_w(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/request_encoder_prio_enc.sv
// Purely combinational fixed-priority encoder: the lowest set bit wins.
// Produces its binary index, a one-hot mask of it and an any-set flag.
module prio_enc
    import request_encoder_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int W = clog2_w(N)
) (
    input  logic [N-1:0] vec_i,
    output logic [W-1:0] idx_o,
    output logic [N-1:0] onehot_o,
    output logic         any_o
);

    // Scan from the top down so the lowest set bit is the last to assign.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        idx_o    = '0;
        onehot_o = '0;
        any_o    = |vec_i;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o       = W'(i);
                onehot_o    = '0;
                onehot_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/request_encoder.sv
// Request encoder: collects request pulses into a pending vector and hands
// out the lowest pending index through a valid/ready output register.
// Flags a one-cycle overflow when a request hits an index already pending.
module request_encoder
    import request_encoder_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int W = clog2_w(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] code,
    output logic [N-1:0] pend,
    output logic         ovf
);

    out_state_e   state_q, state_d;
    logic [W-1:0] code_q,  code_d;
    logic [N-1:0] pend_q,  pend_d;
    logic         ovf_q,   ovf_d;

    logic [W-1:0] pe_idx;
    logic [N-1:0] pe_onehot;
    logic         pe_any;
    logic         out_free;
    logic         load;
    logic [N-1:0] clr;

    // Only the registered pending vector is encoded; same-cycle requests
    // wait for the next edge.
    prio_enc #(
        .N (N),
        .W (W)
    ) u_prio_enc (
        .vec_i    (pend_q),
        .idx_o    (pe_idx),
        .onehot_o (pe_onehot),
        .any_o    (pe_any)
    );

    // Load decision, pending update and overflow detection.
    always_comb begin
        out_free = (state_q == ST_EMPTY) || ready;
        load     = out_free && pe_any;
        clr      = load ? pe_onehot : '0;
        // A new request on the bit being cleared keeps it set.
        pend_d   = (pend_q & ~clr) | req;
        // Re-requesting the index being loaded is a fresh request, not overflow.
        ovf_d    = |(req & pend_q & ~clr);
    end

    // Output FSM next state: load, drain to EMPTY, or hold under backpressure.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        if (load) begin
            state_d = ST_FULL;
            code_d  = pe_idx;
        end else if (out_free) begin
            state_d = ST_EMPTY;
        end
    end

    // All state registers, synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= ST_EMPTY;
            code_q  <= '0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
        end
    end

    assign valid = (state_q == ST_FULL);
    assign code  = code_q;
    assign pend  = pend_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_request_encoder.sv
// Self-checking bench for request_encoder (N=4): directed scenarios with
// fixed expectations, then randomized traffic against a behavioural model.
module tb_request_encoder;

    localparam int N = 4;
    localparam int W = 2;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic         ready;
    logic         valid;
    logic [W-1:0] code;
    logic [N-1:0] pend;
    logic         ovf;

    int checks;
    int failures;

    // Reference model state: a set of pending indices and the output slot.
    bit m_pend [N];
    bit m_valid;
    int m_code;
    bit m_ovf;

    request_encoder #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .ready (ready),
        .valid (valid),
        .code  (code),
        .pend  (pend),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_pend_vec();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < N; i++) if (m_pend[i]) v[i] = 1'b1;
        return v;
    endfunction

    // Advance the model by one edge from the inputs currently driven.
    task automatic model_step();
        int  lowest;
        bit  free;
        bit  any;
        bit  new_ovf;
        if (rst) begin
            for (int i = 0; i < N; i++) m_pend[i] = 0;
            m_valid = 0;
            m_code  = 0;
            m_ovf   = 0;
            return;
        end
        free   = !m_valid || ready;
        any    = 0;
        lowest = -1;
        for (int i = 0; i < N; i++) begin
            if (m_pend[i] && lowest < 0) lowest = i;
            if (m_pend[i]) any = 1;
        end
        new_ovf = 0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && m_pend[i] && !(free && i == lowest)) new_ovf = 1;
        end
        if (free && any) begin
            m_pend[lowest] = 0;
            m_valid = 1;
            m_code  = lowest;
        end else if (free) begin
            m_valid = 0;
        end
        for (int i = 0; i < N; i++) if (req[i]) m_pend[i] = 1;
        m_ovf = new_ovf;
    endtask

    // One clock: update model, let the edge pass, compare all outputs.
    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check({tag, ".valid"}, 32'(valid), 32'(m_valid));
        check({tag, ".code"},  32'(code),  32'(m_code));
        check({tag, ".pend"},  32'(pend),  model_pend_vec());
        check({tag, ".ovf"},   32'(ovf),   32'(m_ovf));
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0;
        tick("reset");
        rst = 1'b0;
    endtask

    initial begin
        int ovf_cycles;
        checks   = 0;
        failures = 0;
        rst = 1'b1; req = '0; ready = 1'b0;
        m_valid = 1; m_code = 3; m_ovf = 1;
        for (int i = 0; i < N; i++) m_pend[i] = 1;

        // Reset state.
        do_reset();
        check("rst_state", {valid, code, pend, ovf}, 32'h0);

        // Single request at index 2, two-edge latency, then drain.
        ready = 1'b1; req = 4'b0100;
        tick("s1a");
        check("s1_not_yet", 32'(valid), 32'h0);
        req = '0;
        tick("s1b");
        check("s1_valid", 32'(valid), 32'h1);
        check("s1_code", 32'(code), 32'h2);
        tick("s1c");
        check("s1_empty", 32'(valid), 32'h0);

        // Multi-request burst delivered back-to-back in priority order.
        req = 4'b1011;
        tick("s2a");
        req = '0;
        tick("s2b"); check("s2_code0", 32'(code), 32'h0);
        tick("s2c"); check("s2_code1", 32'(code), 32'h1);
        tick("s2d"); check("s2_code3", {valid, code}, 32'h7);
        tick("s2e"); check("s2_drained", {valid, pend}, 32'h0);

        // Backpressure holds code and pending.
        do_reset();
        ready = 1'b0; req = 4'b0110;
        tick("s3a");
        req = '0;
        for (int i = 0; i < 5; i++) begin
            tick("s3hold");
            check("s3_hold", {valid, code, pend}, {25'h0, 1'b1, 2'd1, 4'b0100});
        end
        // Overflow on a re-request of a pending index.
        req = 4'b0100;
        tick("s4a");
        check("s4_ovf", 32'(ovf), 32'h1);
        check("s4_pend", 32'(pend), 32'h4);
        req = '0;
        tick("s4b");
        check("s4_ovf_gone", 32'(ovf), 32'h0);
        ready = 1'b1;
        tick("s3b");
        check("s3_code2", {valid, code}, 32'h6);
        tick("s3c");
        check("s3_empty", 32'(valid), 32'h0);

        // Re-request of the index being loaded: no overflow, redelivered.
        req = 4'b0010;
        tick("s5a");
        tick("s5b");
        check("s5_no_ovf", 32'(ovf), 32'h0);
        check("s5_pend1", 32'(pend), 32'h2);
        check("s5_code1", {valid, code}, 32'h5);
        req = '0;
        tick("s5c");
        check("s5_again", {valid, code}, 32'h5);
        tick("s5d");

        // Reset mid-transfer discards everything.
        ready = 1'b0; req = 4'b1110;
        tick("s6a");
        req = '0;
        tick("s6b");
        check("s6_pre", {valid, pend}, 32'h1C);
        rst = 1'b1; req = 4'b1111;
        tick("s6rst");
        rst = 1'b0; req = '0;
        check("s6_cleared", {valid, code, pend, ovf}, 32'h0);

        // Randomized traffic, occasional reset, checked every cycle.
        ovf_cycles = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst   = ($urandom_range(0, 79) == 0);
            ready = ($urandom_range(0, 2) != 0);
            req   = '0;
            for (int i = 0; i < N; i++) req[i] = ($urandom_range(0, 5) == 0);
            tick("rand");
            if (ovf) ovf_cycles++;
        end
        rst = 1'b0; req = '0; ready = 1'b1;
        for (int i = 0; i < N + 2; i++) tick("flush");
        check("flush_empty", {valid, pend}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
